segment_display: RTL and testbench

SEGMENT_DISPLAY -- requirements
Module: segment_display

---
 rtl/segment_display.sv | 94 +++++++++
 tb/tb_segment_display.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/segment_display.sv
// Up/down digit counter driven by two asynchronous push-buttons, shown on a
// seven-segment display. Each button is synchronized and edge-detected before it can move the count.

module segment_display_btn (
  input  logic clk,
  input  logic rst,
  input  logic button,
  output logic press
);
  logic sync1, sync2, prev;

  // sync1/sync2 resolve metastability; prev turns a level into a one-cycle press.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= button;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign press = sync2 & ~prev;
endmodule

module segment_display #(
  parameter int MAX_DIGIT  = 9,
  parameter int ACTIVE_LOW = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       button_plus,
  input  logic       button_minus,
  output logic [6:0] segment
);
  localparam int          NUM_BTN = 2;
  localparam logic [3:0]  MAX     = 4'(MAX_DIGIT);

  logic [NUM_BTN-1:0] btn, press;
  logic [3:0]         count;
  logic [6:0]         pattern;

  assign btn = {button_minus, button_plus};

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    segment_display_btn u_btn (
      .clk    (clk),
      .rst    (rst),
      .button (btn[g]),
      .press  (press[g])
    );
  end

  // press[0] = plus, press[1] = minus; simultaneous presses cancel.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= 4'd0;
    end else begin
      case (press)
        2'b01:   count <= (count >= MAX) ? 4'd0 : count + 4'd1;
        2'b10:   count <= (count == 4'd0) ? MAX : count - 4'd1;
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    pattern = 7'h00;
    case (count)
      4'h0: pattern = 7'h3F;
      4'h1: pattern = 7'h06;
      4'h2: pattern = 7'h5B;
      4'h3: pattern = 7'h4F;
      4'h4: pattern = 7'h66;
      4'h5: pattern = 7'h6D;
      4'h6: pattern = 7'h7D;
      4'h7: pattern = 7'h07;
      4'h8: pattern = 7'h7F;
      4'h9: pattern = 7'h6F;
      4'hA: pattern = 7'h77;
      4'hB: pattern = 7'h7C;
      4'hC: pattern = 7'h39;
      4'hD: pattern = 7'h5E;
      4'hE: pattern = 7'h79;
      4'hF: pattern = 7'h71;
      default: pattern = 7'h00;
    endcase
  end

  // Unregistered so the display tracks count in the same cycle.
  assign segment = (ACTIVE_LOW != 0) ? ~pattern : pattern;
endmodule

// File: tb/tb_segment_display.sv
// Bench for segment_display: directed vector table, hand sequences for the
// wide/inverted build, and random buttons against an edge-history model.

module tb_segment_display;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       bp_a = 1'b0, bm_a = 1'b0, bp_b = 1'b0, bm_b = 1'b0;
  logic [6:0] seg_a, seg_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #10 clk = ~clk;

  segment_display dut_a (
    .clk(clk), .rst(rst), .button_plus(bp_a), .button_minus(bm_a), .segment(seg_a)
  );

  segment_display #(.MAX_DIGIT(15), .ACTIVE_LOW(1)) dut_b (
    .clk(clk), .rst(rst), .button_plus(bp_b), .button_minus(bm_b), .segment(seg_b)
  );

  logic [6:0] tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                          7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Model: a press is seen two edges after its first high sample, provided the
  // sample one edge earlier was low. h*[i][0] = last edge, [1] = two ago, [2] = three ago.
  int mcnt [2];
  bit hp [2][3];
  bit hm [2][3];
  int maxv [2] = '{9, 15};

  function automatic logic [6:0] model_seg(int i);
    logic [6:0] s;
    s = tbl[mcnt[i]];
    return (i == 1) ? ~s : s;
  endfunction

  task automatic model_step();
    bit lp, lm, ep, em;
    for (int i = 0; i < 2; i++) begin
      lp = (i == 0) ? bp_a : bp_b;
      lm = (i == 0) ? bm_a : bm_b;
      if (rst) begin
        mcnt[i] = 0;
        for (int j = 0; j < 3; j++) begin hp[i][j] = 0; hm[i][j] = 0; end
      end else begin
        ep = hp[i][1] && !hp[i][2];
        em = hm[i][1] && !hm[i][2];
        if (ep && !em) mcnt[i] = (mcnt[i] + 1) % (maxv[i] + 1);
        if (em && !ep) mcnt[i] = (mcnt[i] + maxv[i]) % (maxv[i] + 1);
        hp[i][2] = hp[i][1]; hp[i][1] = hp[i][0]; hp[i][0] = lp;
        hm[i][2] = hm[i][1]; hm[i][1] = hm[i][0]; hm[i][0] = lm;
      end
    end
  endtask

  // Advance n rising edges, ending on the following falling edge.
  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      model_step();
      @(negedge clk);
    end
  endtask

  task automatic chk(string name, logic [6:0] act, logic [6:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    bit         r;
    bit         p;
    bit         m;
    int         n;
    logic [6:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic add(bit r, bit p, bit m, int n, logic [6:0] exp);
    vec_t v;
    v.r = r; v.p = p; v.m = m; v.n = n; v.exp = exp;
    vecs.push_back(v);
  endtask

  task automatic press_b(bit up);
    if (up) bp_b = 1'b1; else bm_b = 1'b1;
    tick(1);
    bp_b = 1'b0; bm_b = 1'b0;
    tick(3);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) mcnt[i] = 0;

    // Reset, two-edge latency, up/down/wrap, hold, cancel, reset cases.
    add(1, 0, 0, 1,  7'h3F);   // reset
    add(0, 1, 0, 1,  7'h3F);   // edge k: sampled
    add(0, 0, 0, 1,  7'h3F);   // edge k+1: not yet
    add(0, 0, 0, 1,  7'h06);   // edge k+2: count 1
    add(0, 1, 0, 1,  7'h06);
    add(0, 0, 0, 3,  7'h5B);
    add(0, 0, 1, 1,  7'h5B);
    add(0, 0, 0, 3,  7'h06);
    add(1, 0, 0, 1,  7'h3F);
    add(0, 0, 1, 1,  7'h3F);
    add(0, 0, 0, 3,  7'h6F);   // 0 -> 9
    add(0, 1, 0, 1,  7'h6F);
    add(0, 0, 0, 3,  7'h3F);   // 9 -> 0
    add(0, 1, 0, 2,  7'h3F);   // hold plus
    add(0, 1, 0, 18, 7'h06);
    add(0, 0, 0, 3,  7'h06);
    add(0, 1, 1, 1,  7'h06);   // simultaneous
    add(0, 0, 0, 3,  7'h06);
    add(0, 1, 0, 1,  7'h06);
    add(0, 0, 0, 3,  7'h5B);
    add(0, 1, 0, 1,  7'h5B);
    add(0, 0, 0, 3,  7'h4F);
    add(0, 1, 0, 1,  7'h4F);
    add(0, 0, 0, 3,  7'h66);   // count 4
    add(1, 0, 0, 1,  7'h3F);
    add(0, 1, 0, 1,  7'h3F);   // press in flight...
    add(1, 0, 0, 1,  7'h3F);   // ...killed by reset
    add(0, 0, 0, 3,  7'h3F);
    add(1, 1, 0, 2,  7'h3F);   // reset with press (override)
    add(0, 1, 0, 1,  7'h3F);   // first edge after release
    add(0, 1, 0, 1,  7'h3F);
    add(0, 1, 0, 1,  7'h06);
    add(0, 1, 0, 5,  7'h06);
    add(0, 0, 0, 3,  7'h06);
    add(1, 0, 0, 1,  7'h3F);

    tick(1);
    foreach (vecs[i]) begin
      rst = vecs[i].r; bp_a = vecs[i].p; bm_a = vecs[i].m;
      tick(vecs[i].n);
      chk($sformatf("vec%0d", i), seg_a, vecs[i].exp);
    end
    rst = 1'b0; bp_a = 1'b0; bm_a = 1'b0;

    // Pulse wholly between rising edges must be ignored (count 0 here).
    tick(1);
    #1 bp_a = 1'b1;
    #5 bp_a = 1'b0;
    tick(4);
    chk("short_pulse", seg_a, 7'h3F);

    // Inverted, 0..15 variant.
    chk("b_reset", seg_b, 7'h40);
    for (int i = 1; i <= 4; i++) press_b(1);
    chk("b_at4", seg_b, 7'h19);
    rst = 1'b1; tick(1); rst = 1'b0;
    chk("b_rst4", seg_b, 7'h40);
    for (int i = 1; i <= 15; i++) begin
      press_b(1);
      chk($sformatf("b_up%0d", i), seg_b, ~tbl[i]);
    end
    chk("b_F", seg_b, 7'h0E);
    press_b(1);
    chk("b_wrap_up", seg_b, 7'h40);
    press_b(0);
    chk("b_wrap_dn", seg_b, 7'h0E);

    // Random buttons and occasional reset against the model.
    rst = 1'b1; tick(1); rst = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(3) == 0) bp_a = ~bp_a;
      if ($urandom_range(3) == 0) bm_a = ~bm_a;
      if ($urandom_range(3) == 0) bp_b = ~bp_b;
      if ($urandom_range(3) == 0) bm_b = ~bm_b;
      rst = ($urandom_range(49) == 0);
      tick(1);
      chk("rand_a", seg_a, model_seg(0));
      chk("rand_b", seg_b, model_seg(1));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
